// File: rtl/button_conditioner.sv
// button_conditioner
//   Conditions raw push-button inputs for the Pong logic. Each button is brought
//   into the clk domain through a two-flop synchroniser, then debounced using the
//   rising edge of sample_clk (the clock_divider output) as a sample strobe. A new
//   level is accepted only after STABLE_SAMPLES consecutive samples that all
//   differ from the current level. Every accepted change produces a registered,
//   single-clk press or release pulse that lines up with the level change.
//
//   Optional feature (compile-time macro AUTO_REPEAT_EN):
//     While a button stays pressed, extra btn_press pulses are issued
//     HOLD_DELAY ticks after the press and then every REPEAT_PERIOD ticks.
//     When the macro is undefined, each debounced press gives exactly one pulse,
//     and HOLD_DELAY / REPEAT_PERIOD have no effect.
//
// Ports
//   clk          system clock, all logic on its rising edge
//   rst          asynchronous, active-low reset
//   sample_clk   divided clock; each rising edge is one debounce sample
//   btn_in       raw active-high buttons, asynchronous to clk
//   btn_level    debounced level (registered)
//   btn_press    one-clk pulse on debounced 0->1 (plus auto-repeats)
//   btn_release  one-clk pulse on debounced 1->0
module button_conditioner #(
  parameter int N_BTN          = 4,
  parameter int STABLE_SAMPLES = 4,
  parameter int HOLD_DELAY     = 8,
  parameter int REPEAT_PERIOD  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_clk,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int CNT_W = $clog2(STABLE_SAMPLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

  // A zero-length debounce or repeat interval has no meaning.
  if (STABLE_SAMPLES < 1 || HOLD_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("button_conditioner: STABLE_SAMPLES, HOLD_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic [N_BTN-1:0] btn_meta_p0;
  logic [N_BTN-1:0] btn_s;
  logic             sc_q;
  logic             sc_d;
  logic             tick;
  logic [CNT_W-1:0] cnt [N_BTN];
  logic [N_BTN-1:0] change;
  logic [N_BTN-1:0] rep_fire;

  // Stage p0 -> btn_s: two-flop synchroniser; sample_clk edge detector
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_meta_p0 <= '0;
      btn_s       <= '0;
      sc_q        <= 1'b0;
      sc_d        <= 1'b0;
    end else begin
      btn_meta_p0 <= btn_in;
      btn_s       <= btn_meta_p0;
      sc_q        <= sample_clk;
      sc_d        <= sc_q;
    end
  end

  assign tick = sc_q & ~sc_d;

  // A button accepts its new level on this tick when the last differing
  // sample completes the run.
  always_comb begin
    change = '0;
    for (int i = 0; i < N_BTN; i++) begin
      change[i] = tick && (btn_s[i] != btn_level[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // Stage btn_s -> outputs: debounce counters, level and edge pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      btn_press   <= '0;
      btn_release <= '0;
      if (tick) begin
        for (int i = 0; i < N_BTN; i++) begin
          if (btn_s[i] == btn_level[i]) begin
            // Any agreeing sample throws away the partial run.
            cnt[i] <= '0;
          end else if (change[i]) begin
            cnt[i]       <= '0;
            btn_level[i] <= btn_s[i];
            if (btn_s[i]) begin
              btn_press[i] <= 1'b1;
            end else begin
              btn_release[i] <= 1'b1;
            end
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
          if (rep_fire[i]) begin
            btn_press[i] <= 1'b1;
          end
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int HOLD_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;

  logic [HOLD_W-1:0] hold_cnt [N_BTN];
  logic [N_BTN-1:0]  rep_phase;  // 0: waiting for HOLD_DELAY, 1: repeating
  logic [N_BTN-1:0]  hold_hit;

  always_comb begin
    hold_hit = '0;
    rep_fire = '0;
    for (int i = 0; i < N_BTN; i++) begin
      hold_hit[i] = (hold_cnt[i] + 1'b1) ==
                    (rep_phase[i] ? HOLD_W'(REPEAT_PERIOD) : HOLD_W'(HOLD_DELAY));
      // No repeat on the tick that releases the button.
      rep_fire[i] = tick && btn_level[i] && !change[i] && hold_hit[i];
    end
  end

  // Hold counter: restarted by every accepted level change, advances per tick
  // while the debounced level is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_phase <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        hold_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (change[i]) begin
          hold_cnt[i]  <= '0;
          rep_phase[i] <= 1'b0;
        end else if (tick && btn_level[i]) begin
          if (hold_hit[i]) begin
            hold_cnt[i]  <= '0;
            rep_phase[i] <= 1'b1;
          end else begin
            hold_cnt[i] <= hold_cnt[i] + 1'b1;
          end
        end
      end
    end
  end
`else
  assign rep_fire = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;
  localparam int N  = 4;
  localparam int S  = 4;
  localparam int HD = 3;
  localparam int RP = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sample_clk = 1'b0;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN(N), .STABLE_SAMPLES(S), .HOLD_DELAY(HD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  typedef struct {
    int tick;
    int btn;
    bit rel;
  } ev_t;

  ev_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          tick_no = 0;
  logic [N-1:0] mdl_level;
  logic [31:0] recent [N];   // newest sample in bit 0
  int          nrec [N];     // samples seen since the last accepted change
  int          since [N];    // ticks since the debounced press

  task automatic model_reset();
    mdl_level = '0;
    for (int b = 0; b < N; b++) begin
      recent[b] = '0;
      nrec[b]   = 0;
      since[b]  = 0;
    end
  endtask

  // Reference: a button takes a new level once its last S samples since the
  // previous change all disagree with the current level.
  task automatic model_tick(input logic [N-1:0] s);
    bit all_diff;
    bit changed;
    ev_t e;
    for (int b = 0; b < N; b++) begin
      recent[b] = {recent[b][30:0], s[b]};
      nrec[b]++;
      changed = 1'b0;
      if (nrec[b] >= S) begin
        all_diff = 1'b1;
        for (int k = 0; k < S; k++) begin
          if (recent[b][k] == mdl_level[b]) all_diff = 1'b0;
        end
        if (all_diff) begin
          mdl_level[b] = ~mdl_level[b];
          nrec[b]  = 0;
          since[b] = 0;
          changed  = 1'b1;
          e.tick = tick_no; e.btn = b; e.rel = ~mdl_level[b];
          exp_q.push_back(e);
        end
      end
`ifdef AUTO_REPEAT_EN
      if (!changed && mdl_level[b]) begin
        since[b]++;
        if (since[b] == HD || (since[b] > HD && ((since[b] - HD) % RP) == 0)) begin
          e.tick = tick_no; e.btn = b; e.rel = 1'b0;
          exp_q.push_back(e);
        end
      end
`else
      if (changed) since[b] = 0;
`endif
    end
  endtask

  // One sample period: settle btn_in, raise sample_clk, check the level.
  task automatic do_tick(input logic [N-1:0] v);
    @(negedge clk);
    btn_in = v;
    repeat (3) @(negedge clk);
    sample_clk = 1'b1;
    tick_no++;
    model_tick(v);
    repeat (4) @(negedge clk);
    checks++;
    if (btn_level !== mdl_level) begin
      errors++;
      $display("FAIL level tick=%0d got=%b want=%b", tick_no, btn_level, mdl_level);
    end
    sample_clk = 1'b0;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({btn_level, btn_press, btn_release} !== '0) begin
      errors++;
      $display("FAIL %s got lvl=%b prs=%b rel=%b want all 0", name,
               btn_level, btn_press, btn_release);
    end
  endtask

  // Monitor: every pulse the DUT presents must match the head of the queue.
  task automatic mon_event(input int b, input bit rel);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s btn=%0d tick=%0d got pulse want none",
               rel ? "release" : "press", b, tick_no);
    end else begin
      e = exp_q.pop_front();
      if (e.tick != tick_no || e.btn != b || e.rel != rel) begin
        errors++;
        $display("FAIL pulse got btn=%0d rel=%0d tick=%0d want btn=%0d rel=%0d tick=%0d",
                 b, rel, tick_no, e.btn, e.rel, e.tick);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int b = 0; b < N; b++) begin
        if (btn_press[b] === 1'b1) mon_event(b, 1'b0);
        if (btn_release[b] === 1'b1) mon_event(b, 1'b1);
      end
    end
  end

  initial begin
    logic [N-1:0] v;
    model_reset();

    // Held in reset with all buttons pressed and the strobe running.
    btn_in = '1;
    for (int p = 0; p < 6; p++) begin
      repeat (4) begin
        @(negedge clk);
        check_zero("reset_hold");
      end
      sample_clk = ~sample_clk;
    end
    @(negedge clk);
    rst = 1'b1;

    // All buttons held: change only on the 4th tick.
    repeat (4) do_tick(4'hF);
    repeat (5) do_tick(4'h0);

    // Single press held, no further pulses without auto-repeat.
    repeat (8) do_tick(4'h1);

    // Bounce on button 1 restarts the count.
    do_tick(4'h3); do_tick(4'h3); do_tick(4'h1);
    repeat (4) do_tick(4'h3);

    // Release button 0 while button 1 stays pressed.
    repeat (5) do_tick(4'h2);

    // Buttons 2 and 3 together.
    repeat (5) do_tick(4'hE);
    repeat (5) do_tick(4'h0);

`ifdef AUTO_REPEAT_EN
    // Hold for 10 ticks, then reset before the next repeat.
    repeat (10) do_tick(4'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    do_tick(4'h1);
    @(negedge clk);
    btn_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
`endif

    // Random section: buttons mostly hold, sometimes toggle.
    v = '0;
    for (int t = 0; t < 80; t++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) v[b] = ~v[b];
      end
      do_tick(v);
    end
    repeat (6) do_tick(v);

    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses got %0d outstanding want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
